// File: rtl/io_memory_arbiter.sv
// Arbitrates the shared I/O memory write port between the CPU and NUM_DEVICES round-robin devices.
// Define ARB_STATS_EN to add the saturating word_count output (cycles with a device write).
module io_memory_arbiter #(
  parameter int NUM_DEVICES = 4,
  parameter int MAX_BURST   = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  output logic                      cpu_grant,
  input  logic [NUM_DEVICES-1:0]    dev_start,
  output logic [NUM_DEVICES-1:0]    dev_active,
  input  logic [NUM_DEVICES*17-1:0] dev_address,
  input  logic [NUM_DEVICES*32-1:0] dev_data,
  input  logic [NUM_DEVICES*4-1:0]  dev_wr_en,
  output logic [16:0]               mem_address,
  output logic [31:0]               mem_data_out,
  output logic [3:0]                mem_wr_en
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]               word_count
`endif
);

  localparam int PTR_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DEV} state_t;

  state_t                 r_state;
  logic                   r_cpu_grant;
  logic [NUM_DEVICES-1:0] r_dev_active;
  logic [NUM_DEVICES-1:0] r_pending;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_grant_idx;
  logic [7:0]             r_burst_cnt;

  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_any_pending;
  logic [16:0]            w_sel_addr;
  logic [31:0]            w_sel_data;
  logic [3:0]             w_sel_wr_en;
  logic [NUM_DEVICES-1:0] w_done_mask;
  logic [PTR_W-1:0]       w_next_ptr;
  logic                   w_burst_last;

  // Scan from the highest offset down so the nearest pending index at/after rr_ptr wins.
  always_comb begin
    int j;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    j             = 0;
    w_pick_idx    = r_rr_ptr;
    w_any_pending = 1'b0;
    for (int k = NUM_DEVICES - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_DEVICES) j = j - NUM_DEVICES;
      if (r_pending[PTR_W'(j)]) begin
        w_pick_idx    = PTR_W'(j);
        w_any_pending = 1'b1;
      end
    end
  end

  // Select from the registered one-hot grant; all zero when no device owns the port.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_wr_en = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (r_dev_active[i]) begin
        w_sel_addr  = w_sel_addr  | dev_address[i*17 +: 17];
        w_sel_data  = w_sel_data  | dev_data[i*32 +: 32];
        w_sel_wr_en = w_sel_wr_en | dev_wr_en[i*4 +: 4];
      end
    end
  end

  assign w_done_mask  = (r_state == S_DEV && w_sel_wr_en == 4'h0) ? r_dev_active : '0;
  assign w_next_ptr   = (r_grant_idx == PTR_W'(NUM_DEVICES - 1)) ? '0 : r_grant_idx + 1'b1;
  assign w_burst_last = (r_burst_cnt == 8'(MAX_BURST - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cpu_grant  <= 1'b0;
      r_dev_active <= '0;
      r_pending    <= '0;
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_burst_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge state.
      r_pending <= (r_pending & ~w_done_mask) | dev_start;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_state     <= S_CPU;
            r_cpu_grant <= 1'b1;
          end else if (w_any_pending) begin
            r_state      <= S_DEV;
            r_grant_idx  <= w_pick_idx;
            r_dev_active <= NUM_DEVICES'(1) << w_pick_idx;
            r_burst_cnt  <= '0;
          end
        end
        S_CPU: begin
          if (!cpu_req) begin
            r_state     <= S_IDLE;
            r_cpu_grant <= 1'b0;
          end
        end
        S_DEV: begin
          if (w_sel_wr_en == 4'h0 || w_burst_last) begin
            r_state      <= S_IDLE;
            r_dev_active <= '0;
            r_rr_ptr     <= w_next_ptr;
          end
          if (w_sel_wr_en != 4'h0) r_burst_cnt <= r_burst_cnt + 8'd1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_cpu_grant  <= 1'b0;
          r_dev_active <= '0;
        end
      endcase
    end
  end

  assign cpu_grant    = r_cpu_grant;
  assign dev_active   = r_dev_active;
  assign mem_address  = w_sel_addr;
  assign mem_data_out = w_sel_data;
  assign mem_wr_en    = w_sel_wr_en;

`ifdef ARB_STATS_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word_count <= '0;
    end else if (r_state == S_DEV && w_sel_wr_en != 4'h0 && r_word_count != 32'hFFFF_FFFF) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule
